// File: rtl/mmu_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide SimpleMmu port between opcode fetch (0) and load/store (1).
// Optional watchdog abort is compiled in by defining MMU_ARB_WATCHDOG_EN.
module mmu_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  we0,
    input  logic [DATA_WIDTH-1:0] dataIn0,
    output logic [DATA_WIDTH-1:0] out0,
    output logic                  busy0,
    output logic                  done0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] dataIn1,
    output logic [DATA_WIDTH-1:0] out1,
    output logic                  busy1,
    output logic                  done1,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWriteEnable,
    output logic [DATA_WIDTH-1:0] memDataIn,
    output logic                  memRequest,
    input  logic [DATA_WIDTH-1:0] memOut,
    input  logic                  memBusy,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } stateT;

    stateT state;
    logic  lastGrant;
    logic  grant;
    logic  mask0;
    logic  mask1;
    logic  elig0;
    logic  elig1;
    logic  anyElig;
    logic  pick;

    // A completed requester stays masked until it lets go of its request,
    // so a level-held request is never serviced twice.
    always_comb begin
        elig0   = req0 & ~mask0;
        elig1   = req1 & ~mask1;
        anyElig = elig0 | elig1;
        pick    = 1'b0;
        if (elig0 && elig1) begin
            pick = ~lastGrant;
        end else if (elig1) begin
            pick = 1'b1;
        end
    end

`ifdef MMU_ARB_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wdCount;
    logic            wdExpired;

    // The count starts at 0 on the first edge after the grant, so hitting
    // TIMEOUT-1 means the transaction has been outstanding TIMEOUT cycles.
    assign wdExpired = (wdCount == WD_W'(TIMEOUT - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            lastGrant      <= 1'b1;
            grant          <= 1'b0;
            mask0          <= 1'b0;
            mask1          <= 1'b0;
            out0           <= '0;
            out1           <= '0;
            busy0          <= 1'b0;
            busy1          <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            memAddr        <= '0;
            memWriteEnable <= 1'b0;
            memDataIn      <= '0;
            memRequest     <= 1'b0;
`ifdef MMU_ARB_WATCHDOG_EN
            wdCount        <= '0;
            err            <= 1'b0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (anyElig) begin
                        grant      <= pick;
                        lastGrant  <= pick;
                        memRequest <= 1'b1;
                        state      <= ISSUE;
`ifdef MMU_ARB_WATCHDOG_EN
                        wdCount    <= '0;
`endif
                        if (pick) begin
                            memAddr        <= addr1;
                            memWriteEnable <= we1;
                            memDataIn      <= dataIn1;
                            busy1          <= 1'b1;
                        end else begin
                            memAddr        <= addr0;
                            memWriteEnable <= we0;
                            memDataIn      <= dataIn0;
                            busy0          <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (memBusy) begin
                        state <= WAIT;
                    end
`ifdef MMU_ARB_WATCHDOG_EN
                    else if (wdExpired) begin
                        memRequest <= 1'b0;
                        err        <= 1'b1;
                        state      <= IDLE;
                        if (grant) begin
                            busy1 <= 1'b0;
                            done1 <= 1'b1;
                            out1  <= '1;
                            mask1 <= 1'b1;
                        end else begin
                            busy0 <= 1'b0;
                            done0 <= 1'b1;
                            out0  <= '1;
                            mask0 <= 1'b1;
                        end
                    end
                    wdCount <= wdCount + 1'b1;
`endif
                end

                WAIT: begin
                    if (!memBusy) begin
                        memRequest <= 1'b0;
                        state      <= IDLE;
                        if (grant) begin
                            busy1 <= 1'b0;
                            done1 <= 1'b1;
                            mask1 <= 1'b1;
                            if (!memWriteEnable) begin
                                out1 <= memOut;
                            end
                        end else begin
                            busy0 <= 1'b0;
                            done0 <= 1'b1;
                            mask0 <= 1'b1;
                            if (!memWriteEnable) begin
                                out0 <= memOut;
                            end
                        end
                    end
`ifdef MMU_ARB_WATCHDOG_EN
                    else if (wdExpired) begin
                        memRequest <= 1'b0;
                        err        <= 1'b1;
                        state      <= IDLE;
                        if (grant) begin
                            busy1 <= 1'b0;
                            done1 <= 1'b1;
                            out1  <= '1;
                            mask1 <= 1'b1;
                        end else begin
                            busy0 <= 1'b0;
                            done0 <= 1'b1;
                            out0  <= '1;
                            mask0 <= 1'b1;
                        end
                    end
                    wdCount <= wdCount + 1'b1;
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Placed last so that a dropped request always unmasks, even on
            // the completion edge itself.
            if (!req0) begin
                mask0 <= 1'b0;
            end
            if (!req1) begin
                mask1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed self-checking bench for mmu_port_arbiter; MMU responses are driven by hand.
// Watchdog abort checks run when MMU_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_mmu_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req0;
    logic [31:0] addr0;
    logic        we0;
    logic [7:0]  dataIn0;
    logic [7:0]  out0;
    logic        busy0;
    logic        done0;
    logic        req1;
    logic [31:0] addr1;
    logic        we1;
    logic [7:0]  dataIn1;
    logic [7:0]  out1;
    logic        busy1;
    logic        done1;
    logic [31:0] memAddr;
    logic        memWriteEnable;
    logic [7:0]  memDataIn;
    logic        memRequest;
    logic [7:0]  memOut;
    logic        memBusy;
    logic        err;

    int testsRun;
    int testsFailed;

    mmu_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(8),
        .TIMEOUT   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .addr0         (addr0),
        .we0           (we0),
        .dataIn0       (dataIn0),
        .out0          (out0),
        .busy0         (busy0),
        .done0         (done0),
        .req1          (req1),
        .addr1         (addr1),
        .we1           (we1),
        .dataIn1       (dataIn1),
        .out1          (out1),
        .busy1         (busy1),
        .done1         (done1),
        .memAddr       (memAddr),
        .memWriteEnable(memWriteEnable),
        .memDataIn     (memDataIn),
        .memRequest    (memRequest),
        .memOut        (memOut),
        .memBusy       (memBusy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [31:0] a0, input logic w0, input logic [7:0] d0,
                                 input logic r1, input logic [31:0] a1, input logic w1, input logic [7:0] d1);
        req0 = r0; addr0 = a0; we0 = w0; dataIn0 = d0;
        req1 = r1; addr1 = a1; we1 = w1; dataIn1 = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        memOut      = 8'h00;
        memBusy     = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        #2;
        checkOutput("rst_memRequest", {31'b0, memRequest}, 32'd0);
        checkOutput("rst_busy", {30'b0, busy0, busy1}, 32'd0);
        checkOutput("rst_done", {30'b0, done0, done1}, 32'd0);
        checkOutput("rst_out", {16'b0, out0, out1}, 32'd0);
        checkOutput("rst_memAddr", memAddr, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        #10 reset = 1'b1;

        // Single read from fetch
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        tick();
        checkOutput("rd_memRequest", {31'b0, memRequest}, 32'd1);
        checkOutput("rd_busy0_c1", {31'b0, busy0}, 32'd1);
        checkOutput("rd_memAddr", memAddr, 32'h10);
        checkOutput("rd_memWe", {31'b0, memWriteEnable}, 32'd0);
        memBusy = 1'b1;
        tick();
        checkOutput("rd_busy0_c2", {31'b0, busy0}, 32'd1);
        checkOutput("rd_done0_early", {31'b0, done0}, 32'd0);
        memBusy = 1'b0;
        memOut  = 8'hA5;
        tick();
        checkOutput("rd_done0", {31'b0, done0}, 32'd1);
        checkOutput("rd_out0", {24'b0, out0}, 32'hA5);
        checkOutput("rd_busy0_end", {31'b0, busy0}, 32'd0);
        checkOutput("rd_memRequest_end", {31'b0, memRequest}, 32'd0);
        req0 = 1'b0;
        tick();
        checkOutput("rd_done0_pulse", {31'b0, done0}, 32'd0);

        // Single write from load/store; late dataIn change must be ignored
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 32'h400, 1'b1, 8'h3C);
        tick();
        checkOutput("wr_memRequest", {31'b0, memRequest}, 32'd1);
        checkOutput("wr_memWe", {31'b0, memWriteEnable}, 32'd1);
        checkOutput("wr_memDataIn", {24'b0, memDataIn}, 32'h3C);
        checkOutput("wr_memAddr", memAddr, 32'h400);
        checkOutput("wr_busy", {30'b0, busy0, busy1}, 32'd1);
        dataIn1 = 8'h77;
        memBusy = 1'b1;
        tick();
        checkOutput("wr_memDataIn_held", {24'b0, memDataIn}, 32'h3C);
        memBusy = 1'b0;
        memOut  = 8'h99;
        tick();
        checkOutput("wr_done", {30'b0, done0, done1}, 32'd1);
        checkOutput("wr_out1", {24'b0, out1}, 32'h00);
        checkOutput("wr_out0", {24'b0, out0}, 32'hA5);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        tick();

        // Held request is not re-issued until it drops
        applyStimulus(1'b1, 32'h20, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        tick();
        checkOutput("hold_grant", {31'b0, busy0}, 32'd1);
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'h5A;
        tick();
        checkOutput("hold_done0", {31'b0, done0}, 32'd1);
        checkOutput("hold_out0", {24'b0, out0}, 32'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("hold_noreissue_%0d", i), {30'b0, memRequest, busy0}, 32'd0);
        end
        req0 = 1'b0;
        tick();
        checkOutput("hold_drop", {31'b0, memRequest}, 32'd0);
        req0 = 1'b1;
        tick();
        checkOutput("hold_reissue", {30'b0, memRequest, busy0}, 32'd3);
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'h11;
        tick();
        checkOutput("hold_out0_2", {24'b0, out0}, 32'h11);
        req0 = 1'b0;
        tick();

        // Asynchronous reset while in WAIT
        applyStimulus(1'b1, 32'h30, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        tick();
        memBusy = 1'b1;
        tick();
        checkOutput("arst_pre_busy0", {31'b0, busy0}, 32'd1);
        #3 reset = 1'b0;
        #1;
        checkOutput("arst_memRequest", {31'b0, memRequest}, 32'd0);
        checkOutput("arst_busy0", {31'b0, busy0}, 32'd0);
        req0    = 1'b0;
        memBusy = 1'b0;
        tick();
        checkOutput("arst_nodone", {30'b0, done0, done1}, 32'd0);
        #3 reset = 1'b1;

        // Tie just after reset: order 0,1,0,1
        applyStimulus(1'b1, 32'h100, 1'b0, 8'h00, 1'b1, 32'h200, 1'b0, 8'h00);
        tick();
        checkOutput("tie1_busy", {30'b0, busy0, busy1}, 32'd2);
        checkOutput("tie1_addr", memAddr, 32'h100);
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'hC0;
        tick();
        checkOutput("tie1_done", {30'b0, done0, done1}, 32'd2);
        checkOutput("tie1_out0", {24'b0, out0}, 32'hC0);
        req0 = 1'b0;
        tick();
        checkOutput("tie2_busy", {30'b0, busy0, busy1}, 32'd1);
        checkOutput("tie2_addr", memAddr, 32'h200);
        req0    = 1'b1;
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'hC1;
        tick();
        checkOutput("tie2_done", {30'b0, done0, done1}, 32'd1);
        checkOutput("tie2_out1", {24'b0, out1}, 32'hC1);
        req1 = 1'b0;
        tick();
        checkOutput("tie3_busy", {30'b0, busy0, busy1}, 32'd2);
        checkOutput("tie3_addr", memAddr, 32'h100);
        req1    = 1'b1;
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'hC2;
        tick();
        checkOutput("tie3_out0", {24'b0, out0}, 32'hC2);
        req0 = 1'b0;
        tick();
        checkOutput("tie4_busy", {30'b0, busy0, busy1}, 32'd1);
        checkOutput("tie4_addr", memAddr, 32'h200);
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        memOut  = 8'hC3;
        tick();
        checkOutput("tie4_done", {30'b0, done0, done1}, 32'd1);
        checkOutput("tie4_out1", {24'b0, out1}, 32'hC3);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        tick();

`ifdef MMU_ARB_WATCHDOG_EN
        // Stuck MMU: abort after 8 cycles outstanding
        applyStimulus(1'b1, 32'h40, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00);
        memBusy = 1'b1;
        tick();
        checkOutput("wd_grant", {31'b0, busy0}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput($sformatf("wd_wait_%0d", i), {30'b0, busy0, done0}, 32'd2);
        end
        tick();
        checkOutput("wd_done0", {31'b0, done0}, 32'd1);
        checkOutput("wd_out0", {24'b0, out0}, 32'hFF);
        checkOutput("wd_err", {31'b0, err}, 32'd1);
        checkOutput("wd_idle", {30'b0, memRequest, busy0}, 32'd0);
        req0    = 1'b0;
        memBusy = 1'b0;
        tick();
        tick();
        checkOutput("wd_err_sticky", {31'b0, err}, 32'd1);
`else
        checkOutput("err_tied", {31'b0, err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
